// File: rtl/branch_rs.sv
// Branch reservation station: an age-ordered compacting queue of branch-class
// micro-ops that captures operands from the CDB and issues the oldest ready op
// per cycle onto registered outputs feeding the branch functional unit.
module branch_rs #(
  parameter  int XLEN     = 32,
  parameter  int ROB_SIZE = 256,
  parameter  int RS_DEPTH = 4,
  localparam int TAGW     = $clog2(ROB_SIZE),
  localparam int CW       = $clog2(RS_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            disp_valid,
  output logic            disp_ready,
  input  logic [4:0]      disp_opcode,
  input  logic [2:0]      disp_branch_type,
  input  logic [XLEN-1:0] disp_pc,
  input  logic [XLEN-1:0] disp_offset,
  input  logic [TAGW-1:0] disp_rob_entry,
  input  logic            disp_src1_rdy,
  input  logic [XLEN-1:0] disp_src1_val,
  input  logic [TAGW-1:0] disp_src1_tag,
  input  logic            disp_src2_rdy,
  input  logic [XLEN-1:0] disp_src2_val,
  input  logic [TAGW-1:0] disp_src2_tag,
  input  logic            cdb_valid,
  input  logic [TAGW-1:0] cdb_tag,
  input  logic [XLEN-1:0] cdb_data,
  input  logic            flush,
  output logic            issue_valid,
  output logic [4:0]      issue_opcode,
  output logic [2:0]      issue_branch_type,
  output logic [XLEN-1:0] issue_rs1,
  output logic [XLEN-1:0] issue_rs2,
  output logic [XLEN-1:0] issue_pc,
  output logic [XLEN-1:0] issue_offset,
  output logic [TAGW-1:0] issue_rob_entry,
  output logic [CW-1:0]   occupancy
);

  localparam int IW = $clog2(RS_DEPTH);

  typedef struct packed {
    logic [4:0]      opcode;
    logic [2:0]      btype;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] off;
    logic [TAGW-1:0] rob;
    logic            s1_rdy;
    logic [XLEN-1:0] s1_val;
    logic [TAGW-1:0] s1_tag;
    logic            s2_rdy;
    logic [XLEN-1:0] s2_val;
    logic [TAGW-1:0] s2_tag;
  } entry_t;

  entry_t              ent_reg  [RS_DEPTH];
  entry_t              woken    [RS_DEPTH];
  entry_t              ent_next [RS_DEPTH];
  entry_t              disp_ent;
  logic [CW-1:0]       count_reg;
  logic [CW-1:0]       count_next;
  logic [CW-1:0]       tail;
  logic [RS_DEPTH-1:0] eligible;
  logic [IW-1:0]       sel;
  logic                issue_now;
  logic                accept;

  // Full-stall is decided from the registered count only; a same-cycle issue
  // does not free a slot for dispatch.
  assign disp_ready = (count_reg < CW'(RS_DEPTH));
  assign accept     = disp_valid && disp_ready && !flush;
  assign occupancy  = count_reg;
  assign tail       = count_reg - CW'(issue_now);
  assign count_next = count_reg + CW'(accept) - CW'(issue_now);

  generate
    for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_entry
      // Eligibility uses registered ready bits, so a wakeup this cycle only
      // makes the entry selectable next cycle.
      assign eligible[gi] = (CW'(gi) < count_reg) && ent_reg[gi].s1_rdy && ent_reg[gi].s2_rdy;

      // Capture CDB data into any pending source whose tag matches.
      always_comb begin
        woken[gi] = ent_reg[gi];
        if (cdb_valid && !ent_reg[gi].s1_rdy && (ent_reg[gi].s1_tag == cdb_tag)) begin
          woken[gi].s1_rdy = 1'b1;
          woken[gi].s1_val = cdb_data;
        end
        if (cdb_valid && !ent_reg[gi].s2_rdy && (ent_reg[gi].s2_tag == cdb_tag)) begin
          woken[gi].s2_rdy = 1'b1;
          woken[gi].s2_val = cdb_data;
        end
      end

      // Shift down above the issued slot, then overlay the new op at the tail.
      if (gi < RS_DEPTH - 1) begin : g_shift
        always_comb begin
          ent_next[gi] = woken[gi];
          if (issue_now && (IW'(gi) >= sel)) ent_next[gi] = woken[gi+1];
          if (accept && (CW'(gi) == tail)) ent_next[gi] = disp_ent;
        end
      end else begin : g_top
        always_comb begin
          ent_next[gi] = woken[gi];
          if (accept && (CW'(gi) == tail)) ent_next[gi] = disp_ent;
        end
      end
    end
  endgenerate

  // Oldest-first select: lowest eligible index wins.
  always_comb begin
    issue_now = 1'b0;
    sel       = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        issue_now = 1'b1;
        sel       = IW'(i);
      end
    end
  end

  // Build the incoming entry, bypassing a same-cycle CDB broadcast into pending sources.
  always_comb begin
    disp_ent        = '0;
    disp_ent.opcode = disp_opcode;
    disp_ent.btype  = disp_branch_type;
    disp_ent.pc     = disp_pc;
    disp_ent.off    = disp_offset;
    disp_ent.rob    = disp_rob_entry;
    disp_ent.s1_tag = disp_src1_tag;
    disp_ent.s2_tag = disp_src2_tag;
    disp_ent.s1_rdy = disp_src1_rdy || (cdb_valid && (cdb_tag == disp_src1_tag));
    disp_ent.s1_val = disp_src1_rdy ? disp_src1_val : cdb_data;
    disp_ent.s2_rdy = disp_src2_rdy || (cdb_valid && (cdb_tag == disp_src2_tag));
    disp_ent.s2_val = disp_src2_rdy ? disp_src2_val : cdb_data;
  end

  // Entry payload storage; validity is implied by count_reg.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      ent_reg[i] <= ent_next[i];
    end
  end

  // Count and issue output registers; reset clears everything, flush drops state.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg         <= '0;
      issue_valid       <= 1'b0;
      issue_opcode      <= '0;
      issue_branch_type <= '0;
      issue_rs1         <= '0;
      issue_rs2         <= '0;
      issue_pc          <= '0;
      issue_offset      <= '0;
      issue_rob_entry   <= '0;
    end else if (flush) begin
      count_reg   <= '0;
      issue_valid <= 1'b0;
    end else begin
      count_reg   <= count_next;
      issue_valid <= issue_now;
      if (issue_now) begin
        issue_opcode      <= ent_reg[sel].opcode;
        issue_branch_type <= ent_reg[sel].btype;
        issue_rs1         <= ent_reg[sel].s1_val;
        issue_rs2         <= ent_reg[sel].s2_val;
        issue_pc          <= ent_reg[sel].pc;
        issue_offset      <= ent_reg[sel].off;
        issue_rob_entry   <= ent_reg[sel].rob;
      end
    end
  end

endmodule

// File: tb/tb_branch_rs.sv
// Self-checking bench for branch_rs: directed scenarios followed by random
// traffic, compared each cycle against a queue-based reference model.
module tb_branch_rs;
  localparam int XLEN     = 32;
  localparam int ROB_SIZE = 256;
  localparam int RS_DEPTH = 4;
  localparam int TAGW     = 8;
  localparam int CW       = 3;

  logic            clk = 1'b0;
  logic            rst, disp_valid, disp_ready;
  logic [4:0]      disp_opcode;
  logic [2:0]      disp_branch_type;
  logic [XLEN-1:0] disp_pc, disp_offset;
  logic [TAGW-1:0] disp_rob_entry;
  logic            disp_src1_rdy, disp_src2_rdy;
  logic [XLEN-1:0] disp_src1_val, disp_src2_val;
  logic [TAGW-1:0] disp_src1_tag, disp_src2_tag;
  logic            cdb_valid;
  logic [TAGW-1:0] cdb_tag;
  logic [XLEN-1:0] cdb_data;
  logic            flush;
  logic            issue_valid;
  logic [4:0]      issue_opcode;
  logic [2:0]      issue_branch_type;
  logic [XLEN-1:0] issue_rs1, issue_rs2, issue_pc, issue_offset;
  logic [TAGW-1:0] issue_rob_entry;
  logic [CW-1:0]   occupancy;

  branch_rs #(.XLEN(XLEN), .ROB_SIZE(ROB_SIZE), .RS_DEPTH(RS_DEPTH)) dut (
    .clk(clk), .rst(rst), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_opcode(disp_opcode), .disp_branch_type(disp_branch_type),
    .disp_pc(disp_pc), .disp_offset(disp_offset), .disp_rob_entry(disp_rob_entry),
    .disp_src1_rdy(disp_src1_rdy), .disp_src1_val(disp_src1_val), .disp_src1_tag(disp_src1_tag),
    .disp_src2_rdy(disp_src2_rdy), .disp_src2_val(disp_src2_val), .disp_src2_tag(disp_src2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .flush(flush),
    .issue_valid(issue_valid), .issue_opcode(issue_opcode), .issue_branch_type(issue_branch_type),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_pc(issue_pc), .issue_offset(issue_offset),
    .issue_rob_entry(issue_rob_entry), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  opc;
    logic [2:0]  bt;
    logic [31:0] pc, off;
    logic [7:0]  rob;
    bit          r1, r2;
    logic [31:0] v1, v2;
    logic [7:0]  t1, t2;
  } op_t;

  op_t         q[$];
  logic        exp_iv;
  logic [4:0]  exp_op;
  logic [2:0]  exp_bt;
  logic [31:0] exp_rs1, exp_rs2, exp_pc, exp_off;
  logic [7:0]  exp_rob;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: predict from the model, advance, compare every output.
  task automatic tick();
    op_t o;
    int  n0;
    int  found;
    chk("disp_ready", {63'd0, disp_ready}, (q.size() < RS_DEPTH) ? 64'd1 : 64'd0);
    if (rst || flush) begin
      q.delete();
      exp_iv = 1'b0;
      if (rst) begin
        exp_op = '0; exp_bt = '0; exp_rs1 = '0; exp_rs2 = '0;
        exp_pc = '0; exp_off = '0; exp_rob = '0;
      end
    end else begin
      n0    = q.size();
      found = -1;
      foreach (q[i]) if (found < 0 && q[i].r1 && q[i].r2) found = i;
      if (found >= 0) begin
        exp_iv  = 1'b1;
        exp_op  = q[found].opc; exp_bt  = q[found].bt;
        exp_rs1 = q[found].v1;  exp_rs2 = q[found].v2;
        exp_pc  = q[found].pc;  exp_off = q[found].off;
        exp_rob = q[found].rob;
        q.delete(found);
      end else begin
        exp_iv = 1'b0;
      end
      if (cdb_valid) begin
        foreach (q[i]) begin
          if (!q[i].r1 && q[i].t1 == cdb_tag) begin q[i].r1 = 1'b1; q[i].v1 = cdb_data; end
          if (!q[i].r2 && q[i].t2 == cdb_tag) begin q[i].r2 = 1'b1; q[i].v2 = cdb_data; end
        end
      end
      if (disp_valid && n0 < RS_DEPTH) begin
        o.opc = disp_opcode; o.bt = disp_branch_type; o.pc = disp_pc; o.off = disp_offset;
        o.rob = disp_rob_entry; o.t1 = disp_src1_tag; o.t2 = disp_src2_tag;
        o.r1  = disp_src1_rdy || (cdb_valid && cdb_tag == disp_src1_tag);
        o.v1  = disp_src1_rdy ? disp_src1_val : cdb_data;
        o.r2  = disp_src2_rdy || (cdb_valid && cdb_tag == disp_src2_tag);
        o.v2  = disp_src2_rdy ? disp_src2_val : cdb_data;
        q.push_back(o);
      end
    end
    @(posedge clk);
    #1;
    chk("issue_valid", {63'd0, issue_valid}, {63'd0, exp_iv});
    chk("issue_opcode", {59'd0, issue_opcode}, {59'd0, exp_op});
    chk("issue_branch_type", {61'd0, issue_branch_type}, {61'd0, exp_bt});
    chk("issue_rs1", {32'd0, issue_rs1}, {32'd0, exp_rs1});
    chk("issue_rs2", {32'd0, issue_rs2}, {32'd0, exp_rs2});
    chk("issue_pc", {32'd0, issue_pc}, {32'd0, exp_pc});
    chk("issue_offset", {32'd0, issue_offset}, {32'd0, exp_off});
    chk("issue_rob_entry", {56'd0, issue_rob_entry}, {56'd0, exp_rob});
    chk("occupancy", {61'd0, occupancy}, 64'(q.size()));
    if (issue_valid === 1'b1)
      $display("issue rob=%0d op=%b bt=%0d rs1=%h rs2=%h pc=%h off=%h occ=%0d",
               issue_rob_entry, issue_opcode, issue_branch_type, issue_rs1, issue_rs2,
               issue_pc, issue_offset, occupancy);
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0;
    disp_opcode = '0; disp_branch_type = '0; disp_pc = '0; disp_offset = '0;
    disp_rob_entry = '0; disp_src1_rdy = 1'b0; disp_src1_val = '0; disp_src1_tag = '0;
    disp_src2_rdy = 1'b0; disp_src2_val = '0; disp_src2_tag = '0;
    cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic set_disp(input logic [4:0] opc, input logic [2:0] bt, input logic [31:0] pc,
                          input logic [31:0] off, input logic [7:0] rob,
                          input logic r1, input logic [31:0] v1, input logic [7:0] t1,
                          input logic r2, input logic [31:0] v2, input logic [7:0] t2);
    disp_valid = 1'b1; disp_opcode = opc; disp_branch_type = bt; disp_pc = pc;
    disp_offset = off; disp_rob_entry = rob;
    disp_src1_rdy = r1; disp_src1_val = v1; disp_src1_tag = t1;
    disp_src2_rdy = r2; disp_src2_val = v2; disp_src2_tag = t2;
  endtask

  task automatic set_cdb(input logic [7:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data;
  endtask

  initial begin
    logic [4:0] opcs [4];
    opcs[0] = 5'b11000; opcs[1] = 5'b11011; opcs[2] = 5'b11001; opcs[3] = 5'b00101;
    idle();
    exp_iv = 1'b0; exp_op = '0; exp_bt = '0; exp_rs1 = '0; exp_rs2 = '0;
    exp_pc = '0; exp_off = '0; exp_rob = '0;

    // Reset
    rst = 1'b1;
    @(posedge clk); #1;
    tick();
    chk("reset_occupancy", {61'd0, occupancy}, 64'd0);
    chk("reset_issue_valid", {63'd0, issue_valid}, 64'd0);
    idle();

    // Single ready BEQ: issues two cycles after acceptance
    set_disp(5'b11000, 3'd0, 32'h100, 32'h10, 8'd7, 1'b1, 32'd5, 8'd0, 1'b1, 32'd5, 8'd0);
    tick(); idle(); tick();
    chk("t1_valid", {63'd0, issue_valid}, 64'd1);
    chk("t1_rs1", {32'd0, issue_rs1}, 64'd5);
    chk("t1_pc", {32'd0, issue_pc}, 64'h100);
    chk("t1_rob", {56'd0, issue_rob_entry}, 64'd7);
    chk("t1_occ", {61'd0, occupancy}, 64'd0);
    tick();

    // Pending A then ready B: B first, A after wakeup
    set_disp(5'b11000, 3'd1, 32'h200, 32'h8, 8'd20, 1'b0, 32'd0, 8'd12, 1'b1, 32'd1, 8'd0);
    tick();
    set_disp(5'b11000, 3'd4, 32'h204, 32'hC, 8'd21, 1'b1, 32'd2, 8'd0, 1'b1, 32'd3, 8'd0);
    tick(); idle(); tick();
    chk("t2_b_rob", {56'd0, issue_rob_entry}, 64'd21);
    set_cdb(8'd12, 32'hDEAD); tick(); idle(); tick();
    chk("t2_a_valid", {63'd0, issue_valid}, 64'd1);
    chk("t2_a_rob", {56'd0, issue_rob_entry}, 64'd20);
    chk("t2_a_rs1", {32'd0, issue_rs1}, 64'hDEAD);
    tick();

    // Fill all four entries pending on tag 3
    for (int i = 1; i <= 4; i++) begin
      set_disp(5'b11000, 3'd0, 32'h300 + 32'(i * 4), 32'h4, 8'(i), 1'b0, 32'd0, 8'd3, 1'b1, 32'd9, 8'd0);
      tick();
    end
    idle();
    chk("t3_full_ready", {63'd0, disp_ready}, 64'd0);
    chk("t3_full_occ", {61'd0, occupancy}, 64'd4);
    set_cdb(8'd3, 32'h33); tick(); idle();
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t3_order", {56'd0, issue_rob_entry}, 64'(i));
    end
    tick();

    // Dispatch-time CDB bypass on src2
    set_disp(5'b11000, 3'd5, 32'h400, 32'h20, 8'd50, 1'b1, 32'h11, 8'd0, 1'b0, 32'd0, 8'd9);
    set_cdb(8'd9, 32'h44); tick(); idle(); tick();
    chk("t4_rs2", {32'd0, issue_rs2}, 64'h44);
    chk("t4_rob", {56'd0, issue_rob_entry}, 64'd50);

    // Flush with three resident (one ready) and a concurrent dispatch
    set_disp(5'b11000, 3'd0, 32'h500, 32'h4, 8'd60, 1'b0, 32'd0, 8'd30, 1'b1, 32'd0, 8'd0); tick();
    set_disp(5'b11000, 3'd0, 32'h504, 32'h4, 8'd61, 1'b0, 32'd0, 8'd30, 1'b1, 32'd0, 8'd0); tick();
    set_disp(5'b11011, 3'd0, 32'h508, 32'h4, 8'd62, 1'b1, 32'd0, 8'd0, 1'b1, 32'd0, 8'd0); tick();
    set_disp(5'b11011, 3'd0, 32'h50C, 32'h4, 8'd63, 1'b1, 32'd0, 8'd0, 1'b1, 32'd0, 8'd0);
    flush = 1'b1; tick(); idle();
    chk("t5_occ", {61'd0, occupancy}, 64'd0);
    chk("t5_valid", {63'd0, issue_valid}, 64'd0);
    set_cdb(8'd30, 32'h77); tick(); idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_issue", {63'd0, issue_valid}, 64'd0);
    end

    // Reset while two entries are ready
    set_disp(5'b11000, 3'd0, 32'h600, 32'h4, 8'd70, 1'b0, 32'd0, 8'd40, 1'b1, 32'd0, 8'd0); tick();
    set_disp(5'b11000, 3'd0, 32'h604, 32'h4, 8'd71, 1'b0, 32'd0, 8'd40, 1'b1, 32'd0, 8'd0); tick();
    idle(); set_cdb(8'd40, 32'h88); tick();
    idle(); rst = 1'b1; tick(); idle();
    chk("t6_rs1", {32'd0, issue_rs1}, 64'd0);
    chk("t6_pc", {32'd0, issue_pc}, 64'd0);
    chk("t6_rob", {56'd0, issue_rob_entry}, 64'd0);
    chk("t6_occ", {61'd0, occupancy}, 64'd0);
    chk("t6_ready", {63'd0, disp_ready}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_issue", {63'd0, issue_valid}, 64'd0);
    end

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      idle();
      if ($urandom_range(0, 99) < 60)
        set_disp(opcs[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), $urandom, $urandom,
                 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 7)));
      if ($urandom_range(0, 99) < 45) set_cdb(8'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 99) < 3) flush = 1'b1;
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      tick();
    end
    idle(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_rs.md
Name: branch_rs

Overview:
- Reservation station that sits directly upstream of the branch functional unit.
- Accepts branch-class micro-ops (BRANCH, JAL, JALR, AUIPC) from dispatch and holds them until both source operands are available.
- Captures operand values broadcast on the common data bus (CDB).
- Issues at most one ready op per cycle, oldest first, as registered signals that connect straight to the FU's valid_in/opcode/branch_type/rs1/rs2/pc/offset/rob_entry_in inputs.

Parameters:
- XLEN, 32, datapath width.
- ROB_SIZE, 256, ROB entries; TAGW = $clog2(ROB_SIZE).
- RS_DEPTH, 4, number of station entries (power of two, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- disp_valid  in  1  dispatch offers an op.
- disp_ready  out  1  station can accept; disp_valid&&disp_ready = accept.
- disp_opcode  in  5  opcode[6:2].
- disp_branch_type  in  3  funct3.
- disp_pc  in  XLEN  instruction PC.
- disp_offset  in  XLEN  sign-extended immediate.
- disp_rob_entry  in  TAGW  destination ROB index.
- disp_src1_rdy  in  1  src1 value is valid.
- disp_src1_val  in  XLEN  src1 value.
- disp_src1_tag  in  TAGW  src1 producer tag.
- disp_src2_rdy, disp_src2_val, disp_src2_tag  in  1/XLEN/TAGW  same for src2.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAGW  producing ROB index.
- cdb_data  in  XLEN  produced value.
- flush  in  1  pipeline flush (mispredict/exception).
- issue_valid  out  1  registered; drives FU valid_in.
- issue_opcode  out  5  registered.
- issue_branch_type  out  3  registered.
- issue_rs1, issue_rs2, issue_pc, issue_offset  out  XLEN each  registered.
- issue_rob_entry  out  TAGW  registered.
- occupancy  out  $clog2(RS_DEPTH)+1  valid-entry count.

Behaviour:
- Storage is an age-ordered compacting queue: entry 0 is oldest; valid entries are contiguous from 0; count = occupancy.
- disp_ready = (count < RS_DEPTH).
  - Combinational from the registered count only.
  - No credit for a same-cycle issue: when full, dispatch stalls for one cycle even if an issue occurs.
- Accepted op is written at index count, or count-1 if an issue removes an entry the same cycle.
- disp_rdy=0 means the tag is pending.
- Dispatch-time CDB bypass: if cdb_valid and cdb_tag == a pending src tag, that operand is stored ready with cdb_data.
- Wakeup: every valid entry with a pending src whose tag == cdb_tag while cdb_valid captures cdb_data and marks that src ready. One broadcast may wake both srcs of several entries.
- Eligibility:
  - An entry is eligible when both srcs are ready in registered state.
  - An entry woken in cycle N is eligible in cycle N+1 or later.
- Select: the lowest-index eligible entry is removed. Its fields, with woken values, are registered onto the issue_* outputs; issue_valid=1 the next cycle.
- Compaction: entries above the removed index shift down by one in the same edge.
- No eligible entry: issue_valid=0; the other issue_* outputs hold their last values.
- Latency:
  - An op dispatched with both srcs ready appears on issue_valid 2 cycles after acceptance (one cycle resident, one output register).
  - No back-pressure from the FU; it accepts every cycle.
- Opcodes that need no operands:
  - JAL and AUIPC ops need no rs1/rs2; dispatch drives src_rdy=1 for them.
  - The station does not decode opcodes.
- flush:
  - Next edge: all entries invalid, count=0, issue_valid=0.
  - A dispatch in the flush cycle is dropped.
  - flush has priority over dispatch, wakeup and issue.
- rst: same as flush. In addition, all issue_* data outputs and occupancy are cleared to 0 and disp_ready=1 after reset.
- Simultaneous dispatch+issue at count==RS_DEPTH is impossible because disp_ready=0.
- Simultaneous dispatch+issue with count<RS_DEPTH: count is unchanged and the new op lands at the new tail.

Test Plan:
- Reset, then dispatch BEQ (opcode 11000, type 000, srcs ready rs1=5, rs2=5, pc=0x100, off=0x10, rob=7) → issue_valid=1 two cycles later with rs1=5, rs2=5, pc=0x100, offset=0x10, rob_entry=7; occupancy returns to 0.
- Dispatch op A with src1 pending tag 12, then op B fully ready → B issues first. Then cdb_valid, tag 12, data 0xDEAD → A issues with rs1=0xDEAD two cycles after the broadcast.
- Fill 4 entries, all pending on tag 3 → disp_ready=0 and occupancy=4. Broadcast tag 3 → issue order follows rob 1,2,3,4 on consecutive cycles; disp_ready rises the cycle after the first issue.
- Dispatch with src2 pending tag 9 while cdb_valid, tag 9, data 0x44 in the same cycle → entry stored ready; issues with rs2=0x44 two cycles later.
- Three entries resident and one ready, flush asserted with a concurrent dispatch → next cycle occupancy=0, issue_valid=0, and no later issue of any of those ops.
- Assert rst for one cycle while two entries are ready → all outputs 0 after the edge; nothing issues afterwards.
